// File: rtl/wt_dcache_refill_writer.sv
// Refill writer for the write-through dcache: resolves the victim way of one
// outstanding line miss and turns memory return beats into cache line writes.
module wt_dcache_refill_writer #(
  parameter int unsigned SetAssoc   = 8,
  parameter int unsigned ClIdxWidth = 8,
  parameter int unsigned NumBeats   = 2,
  parameter int unsigned BeatWidth  = 64,
  localparam int unsigned WayW = $clog2(SetAssoc),
  localparam int unsigned OffW = (NumBeats > 1) ? $clog2(NumBeats) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic                  miss_vld_i,
  input  logic [ClIdxWidth-1:0] miss_idx_i,
  input  logic [SetAssoc-1:0]   miss_vld_bits_i,
  output logic                  miss_rdy_o,
  input  logic [WayW-1:0]       repl_way_i,
  output logic                  all_ways_valid_o,
  output logic                  update_lfsr_o,
  input  logic                  rtrn_vld_i,
  input  logic [BeatWidth-1:0]  rtrn_data_i,
  output logic                  wr_cl_vld_o,
  output logic [ClIdxWidth-1:0] wr_cl_idx_o,
  output logic [SetAssoc-1:0]   wr_cl_we_o,
  output logic [OffW-1:0]       wr_cl_off_o,
  output logic [BeatWidth-1:0]  wr_cl_data_o,
  output logic                  fill_done_o,
  output logic                  busy_o
);

  localparam logic [OffW-1:0] LastBeat = OffW'(NumBeats - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    FILL   = 2'd2
  } state_e;

  state_e                r_state;
  logic [ClIdxWidth-1:0] r_idx;
  logic [SetAssoc-1:0]   r_vld_bits;
  logic [WayW-1:0]       r_way;
  logic [OffW-1:0]       r_cnt;
  logic                  r_wr_vld;
  logic [ClIdxWidth-1:0] r_wr_idx;
  logic [SetAssoc-1:0]   r_wr_we;
  logic [OffW-1:0]       r_wr_off;
  logic [BeatWidth-1:0]  r_wr_data;
  logic                  r_fill_done;

  logic                  w_all_valid;
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_last;
  logic [WayW-1:0]       w_victim;

  function automatic logic [WayW-1:0] lowest_zero(input logic [SetAssoc-1:0] bits);
    lowest_zero = '0;
    for (int i = SetAssoc - 1; i >= 0; i--) begin
      if (!bits[i]) begin
        lowest_zero = WayW'(i);
      end
    end
  endfunction

  function automatic logic [SetAssoc-1:0] onehot(input logic [WayW-1:0] way);
    onehot      = '0;
    onehot[way] = 1'b1;
  endfunction

  // Victim is resolved combinationally in SELECT so a beat in that cycle can use it.
  always_comb begin
    w_victim = r_way;
    if (r_state == SELECT) begin
      if (w_all_valid) begin
        w_victim = repl_way_i;
      end else begin
        w_victim = lowest_zero(r_vld_bits);
      end
    end else begin
      w_victim = r_way;
    end
  end

  assign w_all_valid      = &r_vld_bits;
  // The cycle showing the final strobe is kept closed so a new miss starts after it.
  assign miss_rdy_o       = !rst_i && (r_state == IDLE) && !r_fill_done && enable_i && !flush_i;
  assign w_accept         = miss_rdy_o && miss_vld_i;
  assign w_beat           = rtrn_vld_i && (r_state != IDLE);
  assign w_last           = (r_cnt == LastBeat);
  assign all_ways_valid_o = (r_state == SELECT) && w_all_valid;
  assign update_lfsr_o    = (r_state == SELECT) && w_all_valid;
  assign busy_o           = (r_state != IDLE);

  assign wr_cl_vld_o  = r_wr_vld;
  assign wr_cl_idx_o  = r_wr_idx;
  assign wr_cl_we_o   = r_wr_we;
  assign wr_cl_off_o  = r_wr_off;
  assign wr_cl_data_o = r_wr_data;
  assign fill_done_o  = r_fill_done;

  // Control FSM, beat counter and registered write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_vld_bits  <= '0;
      r_way       <= '0;
      r_cnt       <= '0;
      r_wr_vld    <= 1'b0;
      r_wr_idx    <= '0;
      r_wr_we     <= '0;
      r_wr_off    <= '0;
      r_wr_data   <= '0;
      r_fill_done <= 1'b0;
    end else begin
      r_wr_vld    <= w_beat;
      r_fill_done <= w_beat && w_last;
      if (w_beat) begin
        r_wr_idx  <= r_idx;
        r_wr_we   <= onehot(w_victim);
        r_wr_off  <= r_cnt;
        r_wr_data <= rtrn_data_i;
        r_cnt     <= w_last ? '0 : r_cnt + 1'b1;
      end else begin
        r_wr_we   <= '0;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx      <= miss_idx_i;
            r_vld_bits <= miss_vld_bits_i;
            r_state    <= SELECT;
          end else begin
            r_state    <= IDLE;
          end
        end
        SELECT: begin
          r_way   <= w_victim;
          r_state <= (w_beat && w_last) ? IDLE : FILL;
        end
        FILL: begin
          if (w_beat && w_last) begin
            r_state <= IDLE;
          end else begin
            r_state <= FILL;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  wt_dcache_refill_writer_chk #(
    .SetAssoc (SetAssoc)
  ) i_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .busy_i      (busy_o),
    .rtrn_vld_i  (rtrn_vld_i),
    .wr_cl_vld_i (r_wr_vld),
    .wr_cl_we_i  (r_wr_we)
  );

endmodule

// Protocol checker: no return beats while idle, write enables one-hot only with a strobe.
module wt_dcache_refill_writer_chk #(
  parameter int unsigned SetAssoc = 8
) (
  input logic                clk_i,
  input logic                rst_i,
  input logic                busy_i,
  input logic                rtrn_vld_i,
  input logic                wr_cl_vld_i,
  input logic [SetAssoc-1:0] wr_cl_we_i
);

  a_no_beat_in_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rtrn_vld_i && !busy_i));

  a_we_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    (wr_cl_vld_i ? $onehot(wr_cl_we_i) : (wr_cl_we_i == '0)));

endmodule

// File: tb/tb_wt_dcache_refill_writer.sv
// Table-driven bench for wt_dcache_refill_writer plus hand-written reset and
// back-to-back miss sequences.
module tb_wt_dcache_refill_writer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        flush_i;
  logic        miss_vld_i;
  logic [7:0]  miss_idx_i;
  logic [7:0]  miss_vld_bits_i;
  logic        miss_rdy_o;
  logic [2:0]  repl_way_i;
  logic        all_ways_valid_o;
  logic        update_lfsr_o;
  logic        rtrn_vld_i;
  logic [63:0] rtrn_data_i;
  logic        wr_cl_vld_o;
  logic [7:0]  wr_cl_idx_o;
  logic [7:0]  wr_cl_we_o;
  logic [0:0]  wr_cl_off_o;
  logic [63:0] wr_cl_data_o;
  logic        fill_done_o;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  wt_dcache_refill_writer dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .enable_i         (enable_i),
    .flush_i          (flush_i),
    .miss_vld_i       (miss_vld_i),
    .miss_idx_i       (miss_idx_i),
    .miss_vld_bits_i  (miss_vld_bits_i),
    .miss_rdy_o       (miss_rdy_o),
    .repl_way_i       (repl_way_i),
    .all_ways_valid_o (all_ways_valid_o),
    .update_lfsr_o    (update_lfsr_o),
    .rtrn_vld_i       (rtrn_vld_i),
    .rtrn_data_i      (rtrn_data_i),
    .wr_cl_vld_o      (wr_cl_vld_o),
    .wr_cl_idx_o      (wr_cl_idx_o),
    .wr_cl_we_o       (wr_cl_we_o),
    .wr_cl_off_o      (wr_cl_off_o),
    .wr_cl_data_o     (wr_cl_data_o),
    .fill_done_o      (fill_done_o),
    .busy_o           (busy_o)
  );

  // ctl = {rst, enable, flush, miss_vld}; exp = {rdy, awv, upd, wr_vld, fill_done, busy}
  typedef struct {
    logic [3:0]  ctl;
    logic [7:0]  idx;
    logic [7:0]  vb;
    logic [2:0]  rw;
    logic        rv;
    logic [63:0] rd;
    logic [5:0]  exp;
    logic [7:0]  widx;
    logic [7:0]  wwe;
    logic        woff;
    logic [63:0] wdata;
  } vec_t;

  localparam int NV = 24;
  vec_t tv [NV];

  function automatic vec_t v(input logic [3:0] ctl, input logic [7:0] idx, input logic [7:0] vb,
                             input logic [2:0] rw, input logic rv, input logic [63:0] rd,
                             input logic [5:0] exp, input logic [7:0] widx, input logic [7:0] wwe,
                             input logic woff, input logic [63:0] wdata);
    vec_t r;
    r.ctl = ctl; r.idx = idx; r.vb = vb; r.rw = rw; r.rv = rv; r.rd = rd;
    r.exp = exp; r.widx = widx; r.wwe = wwe; r.woff = woff; r.wdata = wdata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_cnt;
    int last_hs;
    int fd_first;
    int hs2;
    int upd_cnt;

    tv[0]  = v(4'b1100, 8'h00, 8'h00, 3'd0, 1'b0, 64'h0,  6'b000000, 8'h00, 8'h00, 1'b0, 64'h0);
    tv[1]  = v(4'b0101, 8'h2A, 8'hF7, 3'd0, 1'b0, 64'h0,  6'b100000, 8'h00, 8'h00, 1'b0, 64'h0);
    tv[2]  = v(4'b0100, 8'h00, 8'h00, 3'd0, 1'b0, 64'h0,  6'b000001, 8'h00, 8'h00, 1'b0, 64'h0);
    tv[3]  = v(4'b0100, 8'h00, 8'h00, 3'd0, 1'b1, 64'h11, 6'b000001, 8'h00, 8'h00, 1'b0, 64'h0);
    tv[4]  = v(4'b0100, 8'h00, 8'h00, 3'd0, 1'b1, 64'h22, 6'b000101, 8'h2A, 8'h08, 1'b0, 64'h11);
    tv[5]  = v(4'b0100, 8'h00, 8'h00, 3'd0, 1'b0, 64'h0,  6'b000110, 8'h2A, 8'h08, 1'b1, 64'h22);
    tv[6]  = v(4'b0101, 8'h05, 8'hFF, 3'd0, 1'b0, 64'h0,  6'b100000, 8'h00, 8'h00, 1'b0, 64'h0);
    tv[7]  = v(4'b0100, 8'h00, 8'h00, 3'd6, 1'b0, 64'h0,  6'b011001, 8'h00, 8'h00, 1'b0, 64'h0);
    tv[8]  = v(4'b0100, 8'h00, 8'h00, 3'd0, 1'b1, 64'hAA, 6'b000001, 8'h00, 8'h00, 1'b0, 64'h0);
    tv[9]  = v(4'b0100, 8'h00, 8'h00, 3'd0, 1'b1, 64'hBB, 6'b000101, 8'h05, 8'h40, 1'b0, 64'hAA);
    tv[10] = v(4'b0100, 8'h00, 8'h00, 3'd0, 1'b0, 64'h0,  6'b000110, 8'h05, 8'h40, 1'b1, 64'hBB);
    tv[11] = v(4'b0101, 8'h33, 8'hFF, 3'd0, 1'b0, 64'h0,  6'b100000, 8'h00, 8'h00, 1'b0, 64'h0);
    tv[12] = v(4'b0100, 8'h00, 8'h00, 3'd3, 1'b1, 64'h5A, 6'b011001, 8'h00, 8'h00, 1'b0, 64'h0);
    tv[13] = v(4'b0100, 8'h00, 8'h00, 3'd0, 1'b1, 64'h5B, 6'b000101, 8'h33, 8'h08, 1'b0, 64'h5A);
    tv[14] = v(4'b0100, 8'h00, 8'h00, 3'd0, 1'b0, 64'h0,  6'b000110, 8'h33, 8'h08, 1'b1, 64'h5B);
    tv[15] = v(4'b0111, 8'h44, 8'h7F, 3'd0, 1'b0, 64'h0,  6'b000000, 8'h00, 8'h00, 1'b0, 64'h0);
    tv[16] = v(4'b0111, 8'h44, 8'h7F, 3'd0, 1'b0, 64'h0,  6'b000000, 8'h00, 8'h00, 1'b0, 64'h0);
    tv[17] = v(4'b0101, 8'h44, 8'h7F, 3'd0, 1'b0, 64'h0,  6'b100000, 8'h00, 8'h00, 1'b0, 64'h0);
    tv[18] = v(4'b0110, 8'h00, 8'h00, 3'd0, 1'b0, 64'h0,  6'b000001, 8'h00, 8'h00, 1'b0, 64'h0);
    tv[19] = v(4'b0110, 8'h00, 8'h00, 3'd0, 1'b1, 64'hC0, 6'b000001, 8'h00, 8'h00, 1'b0, 64'h0);
    tv[20] = v(4'b0010, 8'h00, 8'h00, 3'd0, 1'b1, 64'hC1, 6'b000101, 8'h44, 8'h80, 1'b0, 64'hC0);
    tv[21] = v(4'b0100, 8'h00, 8'h00, 3'd0, 1'b0, 64'h0,  6'b000110, 8'h44, 8'h80, 1'b1, 64'hC1);
    tv[22] = v(4'b0001, 8'h55, 8'h00, 3'd0, 1'b0, 64'h0,  6'b000000, 8'h00, 8'h00, 1'b0, 64'h0);
    tv[23] = v(4'b0100, 8'h00, 8'h00, 3'd0, 1'b0, 64'h0,  6'b100000, 8'h00, 8'h00, 1'b0, 64'h0);

    rst_i = 1'b1; enable_i = 1'b0; flush_i = 1'b0; miss_vld_i = 1'b0;
    miss_idx_i = 8'h00; miss_vld_bits_i = 8'h00; repl_way_i = 3'd0;
    rtrn_vld_i = 1'b0; rtrn_data_i = 64'h0;
    cyc();
    cyc();

    for (int i = 0; i < NV; i++) begin
      {rst_i, enable_i, flush_i, miss_vld_i} = tv[i].ctl;
      miss_idx_i      = tv[i].idx;
      miss_vld_bits_i = tv[i].vb;
      repl_way_i      = tv[i].rw;
      rtrn_vld_i      = tv[i].rv;
      rtrn_data_i     = tv[i].rd;
      #1;
      chk($sformatf("v%0d_miss_rdy", i),  64'(miss_rdy_o),       64'(tv[i].exp[5]));
      chk($sformatf("v%0d_all_valid", i), 64'(all_ways_valid_o), 64'(tv[i].exp[4]));
      chk($sformatf("v%0d_upd_lfsr", i),  64'(update_lfsr_o),    64'(tv[i].exp[3]));
      chk($sformatf("v%0d_wr_vld", i),    64'(wr_cl_vld_o),      64'(tv[i].exp[2]));
      chk($sformatf("v%0d_fill_done", i), 64'(fill_done_o),      64'(tv[i].exp[1]));
      chk($sformatf("v%0d_busy", i),      64'(busy_o),           64'(tv[i].exp[0]));
      chk($sformatf("v%0d_wr_we", i),     64'(wr_cl_we_o),       64'(tv[i].wwe));
      if (tv[i].exp[2]) begin
        chk($sformatf("v%0d_wr_idx", i),  64'(wr_cl_idx_o),  64'(tv[i].widx));
        chk($sformatf("v%0d_wr_off", i),  64'(wr_cl_off_o),  64'(tv[i].woff));
        chk($sformatf("v%0d_wr_data", i), wr_cl_data_o,      tv[i].wdata);
      end
      cyc();
    end

    // Reset after the first beat of a fill, then a fresh miss must start at offset 0.
    rst_i = 1'b0; enable_i = 1'b1; flush_i = 1'b0;
    miss_vld_i = 1'b1; miss_idx_i = 8'h66; miss_vld_bits_i = 8'hFF; repl_way_i = 3'd2;
    rtrn_vld_i = 1'b0; rtrn_data_i = 64'h0;
    #1;
    chk("rst_seq_hs_rdy", 64'(miss_rdy_o), 64'd1);
    cyc();
    miss_vld_i = 1'b0;
    #1;
    chk("rst_seq_select_busy", 64'(busy_o), 64'd1);
    cyc();
    rtrn_vld_i = 1'b1; rtrn_data_i = 64'hD0;
    #1;
    cyc();
    rtrn_vld_i = 1'b0; rst_i = 1'b1;
    #1;
    chk("rst_seq_beat0_vld", 64'(wr_cl_vld_o), 64'd1);
    chk("rst_seq_beat0_we",  64'(wr_cl_we_o),  64'h04);
    cyc();
    #1;
    chk("rst_busy",      64'(busy_o),           64'd0);
    chk("rst_wr_vld",    64'(wr_cl_vld_o),      64'd0);
    chk("rst_wr_we",     64'(wr_cl_we_o),       64'd0);
    chk("rst_wr_idx",    64'(wr_cl_idx_o),      64'd0);
    chk("rst_wr_off",    64'(wr_cl_off_o),      64'd0);
    chk("rst_wr_data",   wr_cl_data_o,          64'd0);
    chk("rst_fill_done", 64'(fill_done_o),      64'd0);
    chk("rst_miss_rdy",  64'(miss_rdy_o),       64'd0);
    chk("rst_all_valid", 64'(all_ways_valid_o), 64'd0);
    chk("rst_upd_lfsr",  64'(update_lfsr_o),    64'd0);
    rst_i = 1'b0; miss_vld_i = 1'b1; miss_idx_i = 8'h77; miss_vld_bits_i = 8'hFD;
    #1;
    chk("post_rst_hs_rdy", 64'(miss_rdy_o), 64'd1);
    cyc();
    miss_vld_i = 1'b0; rtrn_vld_i = 1'b1; rtrn_data_i = 64'hE0;
    #1;
    cyc();
    rtrn_data_i = 64'hE1;
    #1;
    chk("post_rst_wr_vld",  64'(wr_cl_vld_o), 64'd1);
    chk("post_rst_wr_off",  64'(wr_cl_off_o), 64'd0);
    chk("post_rst_wr_we",   64'(wr_cl_we_o),  64'h02);
    chk("post_rst_wr_idx",  64'(wr_cl_idx_o), 64'h77);
    chk("post_rst_wr_data", wr_cl_data_o,     64'hE0);
    cyc();
    rtrn_vld_i = 1'b0;
    #1;
    chk("post_rst_wr_off1",   64'(wr_cl_off_o), 64'd1);
    chk("post_rst_fill_done", 64'(fill_done_o), 64'd1);
    cyc();

    // Two back-to-back misses with miss_vld held high.
    hs_cnt = 0; last_hs = -100; fd_first = -1; hs2 = -1; upd_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      miss_vld_i      = (hs_cnt < 2);
      miss_idx_i      = (hs_cnt == 0) ? 8'h10 : 8'h11;
      miss_vld_bits_i = 8'hFF;
      repl_way_i      = 3'd1;
      rtrn_vld_i      = (c == last_hs + 2) || (c == last_hs + 3);
      rtrn_data_i     = 64'(c);
      #1;
      if (update_lfsr_o) upd_cnt++;
      if (fill_done_o && fd_first < 0) fd_first = c;
      if (miss_vld_i && miss_rdy_o) begin
        hs_cnt++;
        last_hs = c;
        if (hs_cnt == 2) hs2 = c;
      end
      cyc();
    end
    miss_vld_i = 1'b0; rtrn_vld_i = 1'b0;
    chk("b2b_handshakes",   64'(hs_cnt),   64'd2);
    chk("b2b_first_done",   64'(fd_first), 64'd4);
    chk("b2b_second_hs",    64'(hs2),      64'(fd_first + 1));
    chk("b2b_upd_lfsr_cnt", 64'(upd_cnt),  64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wt_dcache_refill_writer.md
Name: wt_dcache_refill_writer

Overview:
- Refill-side writer for the write-through data cache. It accepts one line miss at a time and resolves the victim way: the lowest invalid way if one exists, otherwise the way supplied by the replacement policy.
- It converts returning memory beats into cache line write strobes (wr_cl_vld / wr_cl_idx / wr_cl_we), which are the same events the replacement policy observes.
- It is the producer end of the replacement-policy interface: it drives all_ways_valid and update_lfsr and consumes the replacement way.

Parameters:
- SetAssoc, 8, ways per set; must be a power of two and at least 2.
- ClIdxWidth, 8, set index width.
- NumBeats, 2, memory return beats per cache line; must be a power of two and at least 1.
- BeatWidth, 64, data bits per beat.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  cache enable from CSR.
- flush_i  in  1  flush in progress; blocks new misses.
- miss_vld_i  in  1  miss request valid.
- miss_idx_i  in  ClIdxWidth  set index of the miss.
- miss_vld_bits_i  in  SetAssoc  valid bits of the indexed set, sampled with the miss.
- miss_rdy_o  out  1  miss accepted when miss_vld_i && miss_rdy_o.
- repl_way_i  in  $clog2(SetAssoc)  victim way from the replacement policy.
- all_ways_valid_o  out  1  asserted in SELECT when the latched set has no invalid way.
- update_lfsr_o  out  1  one-cycle pulse in SELECT when repl_way_i is consumed.
- rtrn_vld_i  in  1  memory return beat valid.
- rtrn_data_i  in  BeatWidth  beat data.
- wr_cl_vld_o  out  1  cache line write strobe, registered.
- wr_cl_idx_o  out  ClIdxWidth  write set index.
- wr_cl_we_o  out  SetAssoc  one-hot write way.
- wr_cl_off_o  out  $clog2(NumBeats) (minimum 1 bit)  beat offset within the line.
- wr_cl_data_o  out  BeatWidth  write data.
- fill_done_o  out  1  one-cycle pulse, coincident with the last write strobe.
- busy_o  out  1  high in any state except IDLE.

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge):
  - State goes to IDLE; beat counter, latched index, way and valid bits clear to 0.
  - All outputs are 0, including wr_cl_we_o, wr_cl_data_o and miss_rdy_o.
  - Reset mid-fill abandons the fill; no further writes are issued.
- States:
  - IDLE: miss_rdy_o = enable_i && !flush_i. On handshake, latch miss_idx_i and miss_vld_bits_i, then go to SELECT.
  - SELECT (exactly 1 cycle):
    - If latched valid bits != all-ones, the victim is the lowest-index zero bit; all_ways_valid_o=0 and update_lfsr_o=0.
    - Otherwise the victim is repl_way_i sampled this cycle; all_ways_valid_o=1 and update_lfsr_o=1.
    - Victim is latched and the state goes to FILL.
  - FILL: each rtrn_vld_i cycle writes one beat. After NumBeats beats, go to IDLE.
- Beat handling:
  - A beat arriving in SELECT is accepted and written using the way resolved in that same cycle.
  - Beats arriving in IDLE are dropped; this is a protocol violation, covered by an assertion.
- Write latency:
  - Beat at cycle N produces wr_cl_vld_o=1 at cycle N+1.
  - wr_cl_idx_o = latched index; wr_cl_we_o = onehot(victim); wr_cl_off_o = beat count; wr_cl_data_o = beat data.
- Beat counter:
  - Increments per accepted beat.
  - The last beat (count == NumBeats-1) raises fill_done_o together with that beat's write; the counter wraps to 0.
  - Back-to-back beats on consecutive cycles are supported with no bubbles.
- miss_rdy_o is 0 in SELECT and FILL: one outstanding miss only. A new miss can be accepted in the cycle after the final write strobe.
- enable_i or flush_i asserted mid-fill does not abort the fill; the fill completes normally.
- wr_cl_we_o is always one-hot while wr_cl_vld_o=1, and all-zero otherwise.
- update_lfsr_o fires at most once per miss.

Test Plan:
- Miss idx=0x2A, vld_bits=8'b1111_0111; 2 beats D0=0x11, D1=0x22 on consecutive cycles -> we=8'b0000_1000, all_ways_valid_o=0, update_lfsr_o never pulses, writes off=0/0x11 then off=1/0x22, fill_done_o with the second write.
- Miss idx=0x05, vld_bits=8'hFF, repl_way_i=6 -> all_ways_valid_o=1 and update_lfsr_o=1 for exactly one cycle, every write has we=8'b0100_0000 and idx=0x05.
- Miss accepted with the first beat arriving in the SELECT cycle, vld_bits=8'hFF, repl_way_i=3 -> first write one cycle later with we=8'b0000_1000, off=0.
- flush_i=1 with miss_vld_i=1 in IDLE -> miss_rdy_o=0, no state change. flush_i raised mid-FILL -> remaining beats still written, fill_done_o pulses.
- rst_i asserted after beat 0 of a fill -> next cycle busy_o=0, wr_cl_vld_o=0, all outputs 0. A following miss writes off=0 first (counter cleared).
- Two back-to-back misses (idx 0x10 then 0x11, each with vld_bits=8'hFF) -> second miss_rdy_o handshake completes in the cycle after the first fill_done_o, and update_lfsr_o pulses exactly twice in total.
